// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded fields, operands and control at the end of ID.
// Holds on stall, loads an all-zero bubble on flush or reset, and gates side-effecting control for invalid slots.
module id_ex_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     i_rs_data,
  input  logic [DATA_WIDTH-1:0]     i_rt_data,
  input  logic [DATA_WIDTH-1:0]     i_imm_ext,
  input  logic [4:0]                i_shamt,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [5:0]                i_opcode,
  input  logic [5:0]                i_func_code,
  input  logic                      i_reg_write,
  input  logic                      i_mem_read,
  input  logic                      i_mem_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_alu_src,
  input  logic                      i_mem_unsigned,
  input  logic [1:0]                i_reg_dst,
  input  logic [1:0]                i_mem_width,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_pc_plus4,
  output logic [DATA_WIDTH-1:0]     o_rs_data,
  output logic [DATA_WIDTH-1:0]     o_rt_data,
  output logic [DATA_WIDTH-1:0]     o_imm_ext,
  output logic [4:0]                o_shamt,
  output logic [REG_ADDR_WIDTH-1:0] o_rs_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rt_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
  output logic [5:0]                o_opcode,
  output logic [5:0]                o_func_code,
  output logic                      o_reg_write,
  output logic                      o_mem_read,
  output logic                      o_mem_write,
  output logic                      o_mem_to_reg,
  output logic                      o_alu_src,
  output logic                      o_mem_unsigned,
  output logic [1:0]                o_reg_dst,
  output logic [1:0]                o_mem_width
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [4:0]                shamt;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [5:0]                opcode;
    logic [5:0]                func_code;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      alu_src;
    logic                      mem_unsigned;
    logic [1:0]                reg_dst;
    logic [1:0]                mem_width;
  } entry_t;

  entry_t entry_d, entry_q;

  // An all-zero entry is SLL r0,r0,0: the bubble used by both flush and reset.
  always_comb begin
    entry_d = entry_q;
    if (i_flush) begin
      entry_d = '0;
    end else if (!i_stall) begin
      entry_d.valid        = i_valid;
      entry_d.pc_plus4     = i_pc_plus4;
      entry_d.rs_data      = i_rs_data;
      entry_d.rt_data      = i_rt_data;
      entry_d.imm_ext      = i_imm_ext;
      entry_d.shamt        = i_shamt;
      entry_d.rs_addr      = i_rs_addr;
      entry_d.rt_addr      = i_rt_addr;
      entry_d.rd_addr      = i_rd_addr;
      entry_d.opcode       = i_opcode;
      entry_d.func_code    = i_func_code;
      // A non-valid slot must never write the register file or memory.
      entry_d.reg_write    = i_reg_write  & i_valid;
      entry_d.mem_read     = i_mem_read   & i_valid;
      entry_d.mem_write    = i_mem_write  & i_valid;
      entry_d.mem_to_reg   = i_mem_to_reg & i_valid;
      entry_d.alu_src      = i_alu_src;
      entry_d.mem_unsigned = i_mem_unsigned;
      entry_d.reg_dst      = i_reg_dst;
      entry_d.mem_width    = i_mem_width;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign o_valid        = entry_q.valid;
  assign o_pc_plus4     = entry_q.pc_plus4;
  assign o_rs_data      = entry_q.rs_data;
  assign o_rt_data      = entry_q.rt_data;
  assign o_imm_ext      = entry_q.imm_ext;
  assign o_shamt        = entry_q.shamt;
  assign o_rs_addr      = entry_q.rs_addr;
  assign o_rt_addr      = entry_q.rt_addr;
  assign o_rd_addr      = entry_q.rd_addr;
  assign o_opcode       = entry_q.opcode;
  assign o_func_code    = entry_q.func_code;
  assign o_reg_write    = entry_q.reg_write;
  assign o_mem_read     = entry_q.mem_read;
  assign o_mem_write    = entry_q.mem_write;
  assign o_mem_to_reg   = entry_q.mem_to_reg;
  assign o_alu_src      = entry_q.alu_src;
  assign o_mem_unsigned = entry_q.mem_unsigned;
  assign o_reg_dst      = entry_q.reg_dst;
  assign o_mem_width    = entry_q.mem_width;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, stall, flush, invalid-slot gating and reset priority.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  shamt;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [5:0]  opcode;
    logic [5:0]  func_code;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        mem_unsigned;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_width;
  } ent_t;

  localparam int EW = $bits(ent_t);

  logic clk, reset, stall, flush;
  ent_t din, dout;
  logic [EW-1:0] exp_q[$];
  int n_vec, n_err;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
    .i_valid(din.valid), .i_pc_plus4(din.pc_plus4),
    .i_rs_data(din.rs_data), .i_rt_data(din.rt_data), .i_imm_ext(din.imm_ext),
    .i_shamt(din.shamt), .i_rs_addr(din.rs_addr), .i_rt_addr(din.rt_addr),
    .i_rd_addr(din.rd_addr), .i_opcode(din.opcode), .i_func_code(din.func_code),
    .i_reg_write(din.reg_write), .i_mem_read(din.mem_read), .i_mem_write(din.mem_write),
    .i_mem_to_reg(din.mem_to_reg), .i_alu_src(din.alu_src),
    .i_mem_unsigned(din.mem_unsigned), .i_reg_dst(din.reg_dst), .i_mem_width(din.mem_width),
    .o_valid(dout.valid), .o_pc_plus4(dout.pc_plus4),
    .o_rs_data(dout.rs_data), .o_rt_data(dout.rt_data), .o_imm_ext(dout.imm_ext),
    .o_shamt(dout.shamt), .o_rs_addr(dout.rs_addr), .o_rt_addr(dout.rt_addr),
    .o_rd_addr(dout.rd_addr), .o_opcode(dout.opcode), .o_func_code(dout.func_code),
    .o_reg_write(dout.reg_write), .o_mem_read(dout.mem_read), .o_mem_write(dout.mem_write),
    .o_mem_to_reg(dout.mem_to_reg), .o_alu_src(dout.alu_src),
    .o_mem_unsigned(dout.mem_unsigned), .o_reg_dst(dout.reg_dst), .o_mem_width(dout.mem_width)
  );

  // driver tasks
  task automatic drive(input logic rst, input logic stl, input logic fls, input ent_t v);
    reset = rst;
    stall = stl;
    flush = fls;
    din   = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_entry(input string tag);
    ent_t e;
    e = ent_t'(exp_q.pop_front());
    check({tag, ".valid"},        32'(dout.valid),        32'(e.valid));
    check({tag, ".pc_plus4"},     dout.pc_plus4,          e.pc_plus4);
    check({tag, ".rs_data"},      dout.rs_data,           e.rs_data);
    check({tag, ".rt_data"},      dout.rt_data,           e.rt_data);
    check({tag, ".imm_ext"},      dout.imm_ext,           e.imm_ext);
    check({tag, ".shamt"},        32'(dout.shamt),        32'(e.shamt));
    check({tag, ".rs_addr"},      32'(dout.rs_addr),      32'(e.rs_addr));
    check({tag, ".rt_addr"},      32'(dout.rt_addr),      32'(e.rt_addr));
    check({tag, ".rd_addr"},      32'(dout.rd_addr),      32'(e.rd_addr));
    check({tag, ".opcode"},       32'(dout.opcode),       32'(e.opcode));
    check({tag, ".func_code"},    32'(dout.func_code),    32'(e.func_code));
    check({tag, ".reg_write"},    32'(dout.reg_write),    32'(e.reg_write));
    check({tag, ".mem_read"},     32'(dout.mem_read),     32'(e.mem_read));
    check({tag, ".mem_write"},    32'(dout.mem_write),    32'(e.mem_write));
    check({tag, ".mem_to_reg"},   32'(dout.mem_to_reg),   32'(e.mem_to_reg));
    check({tag, ".alu_src"},      32'(dout.alu_src),      32'(e.alu_src));
    check({tag, ".mem_unsigned"}, 32'(dout.mem_unsigned), 32'(e.mem_unsigned));
    check({tag, ".reg_dst"},      32'(dout.reg_dst),      32'(e.reg_dst));
    check({tag, ".mem_width"},    32'(dout.mem_width),    32'(e.mem_width));
  endtask

  task automatic expect_entry(input string tag, input ent_t e);
    exp_q.push_back(EW'(e));
    check_entry(tag);
  endtask

  ent_t ones_v, addu_v, b_v, lw_v, c_v, inv_v, inv_exp, d_v, e_v, zero_v;

  initial begin
    n_vec = 0;
    n_err = 0;
    zero_v = '0;
    ones_v = '1;

    addu_v = '0;
    addu_v.valid = 1'b1;   addu_v.pc_plus4 = 32'h0000_0104;
    addu_v.rs_data = 32'd5; addu_v.rt_data = 32'd7;
    addu_v.rs_addr = 5'd1; addu_v.rt_addr = 5'd2; addu_v.rd_addr = 5'd3;
    addu_v.opcode = 6'h00; addu_v.func_code = 6'h21;
    addu_v.reg_write = 1'b1; addu_v.reg_dst = 2'd1; addu_v.mem_width = 2'd3;

    b_v = '0;
    b_v.valid = 1'b1; b_v.pc_plus4 = 32'h0000_0108; b_v.rs_data = 32'hDEAD_BEEF;
    b_v.rt_data = 32'h0BAD_F00D; b_v.imm_ext = 32'hFFFF_FFF0; b_v.shamt = 5'd17;
    b_v.rs_addr = 5'd9; b_v.rt_addr = 5'd10; b_v.rd_addr = 5'd11;
    b_v.opcode = 6'h08; b_v.func_code = 6'h30; b_v.reg_write = 1'b1;
    b_v.alu_src = 1'b1; b_v.reg_dst = 2'd0; b_v.mem_width = 2'd1;

    lw_v = '0;
    lw_v.valid = 1'b1; lw_v.pc_plus4 = 32'h0000_010C; lw_v.rs_data = 32'h1000_0000;
    lw_v.imm_ext = 32'h0000_0004; lw_v.rs_addr = 5'd29; lw_v.rt_addr = 5'd8;
    lw_v.opcode = 6'h23; lw_v.reg_write = 1'b1; lw_v.mem_read = 1'b1;
    lw_v.mem_to_reg = 1'b1; lw_v.alu_src = 1'b1; lw_v.mem_width = 2'd3;

    c_v = b_v;
    c_v.rs_data = 32'h5555_AAAA; c_v.opcode = 6'h2B; c_v.mem_write = 1'b1;

    inv_v = '0;
    inv_v.valid = 1'b0; inv_v.pc_plus4 = 32'h0000_0200; inv_v.rs_data = 32'h0000_1234;
    inv_v.rt_data = 32'h0000_5678; inv_v.rs_addr = 5'd4; inv_v.rt_addr = 5'd5;
    inv_v.opcode = 6'h2B; inv_v.reg_write = 1'b1; inv_v.mem_read = 1'b1;
    inv_v.mem_write = 1'b1; inv_v.mem_to_reg = 1'b1; inv_v.alu_src = 1'b1;
    inv_v.mem_unsigned = 1'b1; inv_v.reg_dst = 2'd2; inv_v.mem_width = 2'd0;
    // Hand-gated: data and non-side-effect controls pass, the four side-effect bits drop.
    inv_exp = inv_v;
    inv_exp.reg_write = 1'b0; inv_exp.mem_read = 1'b0;
    inv_exp.mem_write = 1'b0; inv_exp.mem_to_reg = 1'b0;

    d_v = addu_v;
    d_v.rs_data = 32'hCAFE_0001; d_v.rd_addr = 5'd31; d_v.reg_dst = 2'd2;
    e_v = addu_v;
    e_v.rt_data = 32'h8000_0000; e_v.mem_unsigned = 1'b1; e_v.reg_dst = 2'd3;

    // Reset held 2 edges with every other input at ones (stall/flush included).
    drive(1'b1, 1'b1, 1'b1, ones_v);
    tick();
    expect_entry("reset1", zero_v);
    tick();
    expect_entry("reset2", zero_v);

    // First edge after release loads all-ones (reg_dst=3 passes as-is).
    drive(1'b0, 1'b0, 1'b0, ones_v);
    tick();
    expect_entry("load_ones", ones_v);

    // Normal load: ADDU.
    drive(1'b0, 1'b0, 1'b0, addu_v);
    tick();
    expect_entry("addu", addu_v);

    // Stall 3 edges with B at input, then release.
    drive(1'b0, 1'b1, 1'b0, b_v);
    tick();
    expect_entry("stall1", addu_v);
    tick();
    expect_entry("stall2", addu_v);
    tick();
    expect_entry("stall3", addu_v);
    drive(1'b0, 1'b0, 1'b0, b_v);
    tick();
    expect_entry("unstall", b_v);

    // Flush with stall together on a valid LW gives a bubble.
    drive(1'b0, 1'b1, 1'b1, lw_v);
    tick();
    expect_entry("flush_stall", zero_v);

    // Stall after flush holds the bubble.
    drive(1'b0, 1'b1, 1'b0, c_v);
    tick();
    expect_entry("stall_bubble", zero_v);

    // Load C then load-use style flush (flush=1, stall=0), twice back to back.
    drive(1'b0, 1'b0, 1'b0, c_v);
    tick();
    expect_entry("load_c", c_v);
    drive(1'b0, 1'b0, 1'b1, lw_v);
    tick();
    expect_entry("flush1", zero_v);
    drive(1'b0, 1'b0, 1'b1, b_v);
    tick();
    expect_entry("flush2", zero_v);

    // Invalid slot.
    drive(1'b0, 1'b0, 1'b0, inv_v);
    tick();
    expect_entry("invalid", inv_exp);

    // Reset mid-stall.
    drive(1'b0, 1'b0, 1'b0, d_v);
    tick();
    expect_entry("load_d", d_v);
    drive(1'b0, 1'b1, 1'b0, e_v);
    tick();
    expect_entry("hold_d", d_v);
    drive(1'b1, 1'b1, 1'b0, e_v);
    tick();
    expect_entry("reset_stall", zero_v);
    drive(1'b0, 1'b0, 1'b0, e_v);
    tick();
    expect_entry("load_e", e_v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
